// File: rtl/sat_narrow_pipe.sv
// Narrows IN_W-bit words to OUT_W-bit halfwords with signed/unsigned saturation,
// buffering results in a 2-entry FIFO and counting overflow events.
module sat_narrow_pipe #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    logic [1:0][OUT_W-1:0] data_q, data_d;
    logic [1:0]            ovf_q, ovf_d;
    logic [1:0]            occ_q, occ_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic                  sticky_q, sticky_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  accept, pop;
    logic [OUT_W-1:0]      sat_data;
    logic                  sat_ovf;
    logic [IN_W-OUT_W:0]   sign_bits;

    assign in_ready   = (occ_q != 2'd2);
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = data_q[head_q];
    assign out_ovf    = ovf_q[head_q];
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign sign_bits = in_data[IN_W-1:OUT_W-1];

    // Signed fits when every bit above the halfword sign bit matches it.
    always_comb begin
        sat_data = in_data[OUT_W-1:0];
        sat_ovf  = 1'b0;
        if (in_signed) begin
            if (!((&sign_bits) || (~|sign_bits))) begin
                sat_ovf  = 1'b1;
                sat_data = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end else if (in_data[IN_W-1:OUT_W] != '0) begin
            sat_ovf  = 1'b1;
            sat_data = '1;
        end
    end

    always_comb begin
        data_d = data_q;
        ovf_d  = ovf_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (accept) begin
            data_d[tail_q] = sat_data;
            ovf_d[tail_q]  = sat_ovf;
            tail_d         = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // A new overflow on the same edge as a clear survives as count=1.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (accept && sat_ovf) begin
            sticky_d = 1'b1;
            if (clr_ovf) begin
                count_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end else if (clr_ovf) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            ovf_q    <= '0;
            occ_q    <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_sat_narrow_pipe.sv
// Bench for sat_narrow_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_sat_narrow_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        clr_ovf = 1'b0;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] d;
        logic        o;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] seen[$];
    bit          m_sticky;
    int          m_count;

    sat_narrow_pipe #(.IN_W(32), .OUT_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t narrow(input logic [31:0] d, input logic s);
        ent_t   e;
        longint v;
        if (s) begin
            v = longint'($signed(d));
            if (v > 32767) begin
                e.d = 16'h7FFF; e.o = 1'b1;
            end else if (v < -32768) begin
                e.d = 16'h8000; e.o = 1'b1;
            end else begin
                e.d = d[15:0];  e.o = 1'b0;
            end
        end else begin
            v = longint'(d);
            if (v > 65535) begin
                e.d = 16'hFFFF; e.o = 1'b1;
            end else begin
                e.d = d[15:0];  e.o = 1'b0;
            end
        end
        return e;
    endfunction

    // Reference model plus pop monitor; inputs change only #1 after edges.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_sticky = 1'b0;
            m_count  = 0;
        end else begin
            bit   acc, pp;
            ent_t e;
            acc = in_valid && (mq.size() < 2);
            pp  = out_ready && (mq.size() > 0);
            if (out_valid && out_ready) seen.push_back(out_data);
            e = narrow(in_data, in_signed);
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (acc && e.o) begin
                m_sticky = 1'b1;
                if (clr_ovf) m_count = 1;
                else if (m_count < 255) m_count++;
            end else if (clr_ovf) begin
                m_sticky = 1'b0;
                m_count  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", in_ready, mq.size() != 2);
            check("out_valid", out_valid, mq.size() != 0);
            if (mq.size() > 0) begin
                check("out_data", out_data, mq[0].d);
                check("out_ovf", out_ovf, mq[0].o);
            end
            check("ovf_sticky", ovf_sticky, m_sticky);
            check("ovf_count", ovf_count, m_count);
        end
    end

    task automatic push(input logic [31:0] d, input logic s);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] sv_in  [4] = '{32'h00007FFF, 32'h00008000, 32'hFFFF8000, 32'hFFFF7FFF};
    logic [15:0] sv_out [4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic        sv_ovf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] bp_exp [3] = '{16'h000A, 16'h000B, 16'h000C};

    initial begin
        idle(3);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_count", ovf_count, 0);
        rst = 1'b1;
        idle(1);
        check("post_rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        push(32'h00001234, 1'b1);
        check("pass_valid", out_valid, 1);
        check("pass_data", out_data, 16'h1234);
        check("pass_ovf", out_ovf, 0);

        for (int i = 0; i < 4; i++) begin
            push(sv_in[i], 1'b1);
            check("signed_data", out_data, sv_out[i]);
            check("signed_ovf", out_ovf, sv_ovf[i]);
        end
        idle(1);
        check("signed_count", ovf_count, 2);
        check("signed_sticky", ovf_sticky, 1);

        push(32'h0000FFFF, 1'b0);
        check("uns_data0", out_data, 16'hFFFF);
        check("uns_ovf0", out_ovf, 0);
        push(32'h00010000, 1'b0);
        check("uns_data1", out_data, 16'hFFFF);
        check("uns_ovf1", out_ovf, 1);
        idle(2);

        seen.delete();
        out_ready = 1'b0;
        push(32'h0000000A, 1'b0);
        check("bp_ready1", in_ready, 1);
        push(32'h0000000B, 1'b0);
        check("bp_ready2", in_ready, 0);
        in_valid = 1'b1; in_data = 32'h0000000C; in_signed = 1'b0;
        idle(3);
        check("bp_held_ready", in_ready, 0);
        check("bp_held_data", out_data, 16'h000A);
        out_ready = 1'b1;
        push(32'h0000000C, 1'b0);
        idle(3);
        check("bp_count", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) check("bp_order", seen[i], bp_exp[i]);

        for (int i = 0; i < 300; i++) push(32'h00010000, 1'b0);
        idle(1);
        check("sat_count", ovf_count, 255);
        clr_ovf = 1'b1;
        push(32'h80000000, 1'b1);
        clr_ovf = 1'b0;
        check("clr_ovf_evt_count", ovf_count, 1);
        check("clr_ovf_evt_sticky", ovf_sticky, 1);
        check("clr_ovf_evt_data", out_data, 16'h8000);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        check("clr_count", ovf_count, 0);
        check("clr_sticky", ovf_sticky, 0);
        idle(2);

        out_ready = 1'b0;
        push(32'h00000001, 1'b0);
        push(32'h00000002, 1'b0);
        check("ar_full", in_ready, 0);
        #3;
        rst = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        check("ar_in_ready", in_ready, 1);
        out_ready = 1'b1;
        push(32'h00000055, 1'b0);
        check("ar_first_data", out_data, 16'h0055);
        check("ar_first_valid", out_valid, 1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
